hybrid_add_seq: RTL and testbench

Multi-cycle sequencer that performs BYTES-wide addition or subtraction by driving one instance of the 8-bit hybrid adder (`hybridadder8_struct`) once per byte, least-significant byte first. Each byte's carry-out feeds the next byte's carry-in. The block sits between a requester and the shared 8-bit adder datapath. It accepts one operation at a time over a valid/ready handshake and returns the full-width result, carry/borrow and signed overflow over a second valid/ready handshake.

---
 rtl/hybrid_add_seq.sv | 147 ++++++++++++++
 tb/tb_hybrid_add_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_add_seq.sv
// Multi-byte add/subtract sequencer: reuses one 8-bit hybrid (nibble-lookahead,
// nibble-ripple) adder per byte, LSB first, with the carry chained through a register.

module hybridadder8_struct (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       c0,
  output logic [7:0] s,
  output logic       c8
);
  logic [7:0] g, p;
  logic [4:0] lo, hi;

  // 4-bit carry lookahead; returns {c4,c3,c2,c1,cin}
  function automatic logic [4:0] cla4(input logic [3:0] gi, input logic [3:0] pi,
                                      input logic ci);
    logic [4:0] cc;
    cc[0] = ci;
    cc[1] = gi[0] | (pi[0] & ci);
    cc[2] = gi[1] | (pi[1] & gi[0]) | (&pi[1:0] & ci);
    cc[3] = gi[2] | (pi[2] & gi[1]) | (&pi[2:1] & gi[0]) | (&pi[2:0] & ci);
    cc[4] = gi[3] | (pi[3] & gi[2]) | (&pi[3:2] & gi[1]) | (&pi[3:1] & gi[0])
          | (&pi[3:0] & ci);
    return cc;
  endfunction

  assign g  = x & y;
  assign p  = x ^ y;
  assign lo = cla4(g[3:0], p[3:0], c0);
  assign hi = cla4(g[7:4], p[7:4], lo[4]);
  assign s  = p ^ {hi[3:0], lo[3:0]};
  assign c8 = hi[4];
endmodule

module hybrid_add_seq #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] a,
  input  logic [8*BYTES-1:0] b,
  input  logic               cin,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*BYTES-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy,
  output logic [1:0]         state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; ready/valid here depend on state only, and out_valid holds until taken.
  localparam int W  = 8 * BYTES;
  localparam int IW = $clog2(BYTES);
  localparam logic [IW-1:0] LAST = IW'(BYTES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  a_reg, b_reg, sum_reg;
  logic          carry_reg, cout_reg, ovf_reg;
  logic [IW-1:0] idx;
  logic [7:0]    xi, yi, si;
  logic          c8;

  assign xi = a_reg[8*idx +: 8];
  assign yi = b_reg[8*idx +: 8];

  hybridadder8_struct u_add (
    .x  (xi),
    .y  (yi),
    .c0 (carry_reg),
    .s  (si),
    .c8 (c8)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (idx == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert b once at capture and force the first carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b ^ {W{sub}};
            carry_reg <= sub | cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_reg[8*idx +: 8] <= si;
          carry_reg           <= c8;
          if (idx == LAST) begin
            cout_reg <= c8;
            ovf_reg  <= a_reg[W-1] ^ b_reg[W-1] ^ si[7] ^ c8;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;
  assign state_dbg = state;
endmodule

// File: tb/tb_hybrid_add_seq.sv
// Bench for hybrid_add_seq: full-width arithmetic model, scoreboard queue, directed
// vectors, backpressure, ignored requests, mid-operation reset and random traffic.

module tb_hybrid_add_seq;
  localparam int BYTES = 4;
  localparam int W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] sum;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  hybrid_add_seq #(.BYTES(BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Expected results as {cout, ovf, sum}
  logic [W+1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Full-width arithmetic; overflow when both addends share a sign the result lacks.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mcin, input logic msub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         ci, o;
    bb   = msub ? ~mb : mb;
    ci   = msub ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
    o    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    return {full[W], o, full[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Scoreboard: every DONE cycle must show the oldest outstanding result.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", out_valid, 0);
      end else begin
        chk("sum", sum, exp_q[0][W-1:0]);
        chk("ovf", ovf, exp_q[0][W]);
        chk("cout", cout, exp_q[0][W+1]);
        chk("in_ready_in_done", in_ready, 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // hold < 0: out_ready already high when the result appears.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                        input logic osub, input int hold, input bit pulse);
    int n;
    logic [W+1:0] e;
    e = model(oa, ob, ocin, osub);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", in_ready, 1);
    if (!in_ready) return;
    a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (hold < 0) out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    n = 0;
    while (!out_valid && n < BYTES + 8) begin
      chk("in_ready_in_run", in_ready, 0);
      chk("busy_in_run", busy, 1);
      in_valid = (pulse && n == 1);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, BYTES);
    if (!out_valid) begin
      out_ready = 1'b0;
      return;
    end
    if (hold >= 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("hold_out_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
    end
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("out_valid_after_ack", out_valid, 0);
    chk("in_ready_after_ack", in_ready, 1);
    chk("sum_kept", sum, e[W-1:0]);
    chk("cout_kept", cout, e[W+1]);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    // Pin the model to hand-computed results.
    chk("pin_byte_carry", model(32'h000000FF, 32'h00000001, 1'b0, 1'b0), {2'b00, 32'h00000100});
    chk("pin_ripple",     model(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0), {2'b10, 32'h00000000});
    chk("pin_ovf",        model(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0), {2'b01, 32'h80000000});
    chk("pin_borrow",     model(32'h00000005, 32'h00000007, 1'b1, 1'b1), {2'b00, 32'hFFFFFFFE});
    chk("pin_noborrow",   model(32'h80000000, 32'h00000001, 1'b0, 1'b1), {2'b11, 32'h7FFFFFFF});
    chk("pin_after_rst",  model(32'h12345678, 32'h11111111, 1'b0, 1'b0), {2'b00, 32'h23456789});

    @(negedge clk);
    reset_checks("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, 1'b0);
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, -1, 1'b0);
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1, 1'b0);
    run_op(32'h00000005, 32'h00000007, 1'b1, 1'b1, 0, 1'b0);
    run_op(32'h80000000, 32'h00000001, 1'b0, 1'b1, 0, 1'b0);
    run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, 3, 1'b1);
    run_op(32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, -1, 1'b0);

    // Abort two cycles into RUN; partially written sum must be cleared.
    @(negedge clk);
    a = 32'h01010101; b = 32'h02020202; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_checks("midrun_reset");
    @(negedge clk);
    chk("midrun_no_out_valid", out_valid, 0);
    rst_n = 1'b1;
    run_op(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(pick(), pick(), 1'($urandom), 1'($urandom), $urandom_range(0, 4) - 1,
             1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
